// File: rtl/fp_alu_pkg.sv
// rtl/fp_alu_pkg.sv - shared constants for the floating-point operand datapath
package fp_alu_pkg;

  localparam logic PRIO_RR    = 1'b0;
  localparam logic PRIO_FIXED = 1'b1;

  localparam int MANT_W = 24;
  localparam int EXP_W  = 8;
  localparam int SIGN_W = 1;

endpackage

// File: rtl/fp_rr_arbiter.sv
// rtl/fp_rr_arbiter.sv - combinational round-robin / fixed-priority arbiter
module fp_rr_arbiter
  import fp_alu_pkg::*;
#(
  parameter  int NCH  = 4,
  localparam int IDXW = $clog2(NCH)
) (
  input  logic [NCH-1:0]  req,
  input  logic [IDXW-1:0] ptr,
  input  logic            mode,
  output logic [NCH-1:0]  gnt,
  output logic [IDXW-1:0] gnt_idx,
  output logic            any_gnt
);

  localparam int PW = IDXW + 1;

  logic [PW-1:0] pos;

  // Both searches run from the far end down so the nearest candidate is written last.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    any_gnt = 1'b0;
    pos     = '0;
    if (mode == PRIO_FIXED) begin
      for (int i = NCH - 1; i >= 0; i--) begin
        if (req[i]) begin
          gnt_idx = IDXW'(i);
          any_gnt = 1'b1;
        end
      end
    end else begin
      for (int k = NCH - 1; k >= 0; k--) begin
        pos = {1'b0, ptr} + PW'(k);
        if (pos >= PW'(NCH)) begin
          pos = pos - PW'(NCH);
        end
        if (req[pos[IDXW-1:0]]) begin
          gnt_idx = pos[IDXW-1:0];
          any_gnt = 1'b1;
        end
      end
    end
    if (any_gnt) begin
      gnt[gnt_idx] = 1'b1;
    end
  end

endmodule

// File: rtl/fp_rr_mux_stage.sv
// rtl/fp_rr_mux_stage.sv - N-channel arbitrated operand selector with one-entry output register
module fp_rr_mux_stage
  import fp_alu_pkg::*;
#(
  parameter  int WIDTH = MANT_W,
  parameter  int NCH   = 4,
  localparam int IDXW  = $clog2(NCH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 prio_mode,
  input  logic [NCH-1:0]       in_valid,
  input  logic [NCH*WIDTH-1:0] in_data,
  output logic [NCH-1:0]       in_ready,
  output logic                 out_valid,
  output logic [WIDTH-1:0]     out_data,
  output logic [IDXW-1:0]      out_ch,
  input  logic                 out_ready
);

  logic [IDXW-1:0]  ptr;
  logic [IDXW-1:0]  ptr_next;
  logic [NCH-1:0]   gnt;
  logic [IDXW-1:0]  gnt_idx;
  logic             any_gnt;
  logic             load;
  logic [WIDTH-1:0] ch_data [NCH];

  fp_rr_arbiter #(.NCH(NCH)) u_arb (
    .req     (in_valid),
    .ptr     (ptr),
    .mode    (prio_mode),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .any_gnt (any_gnt)
  );

  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      ch_data[i] = in_data[i*WIDTH +: WIDTH];
    end
  end

  assign load     = !out_valid || out_ready;
  assign ptr_next = (gnt_idx == IDXW'(NCH - 1)) ? '0 : gnt_idx + 1'b1;
  // Ready is gated by reset so nothing is acknowledged while state is being cleared.
  assign in_ready = (rst_n && load) ? gnt : '0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      ptr       <= '0;
    end else if (load) begin
      if (any_gnt) begin
        out_valid <= 1'b1;
        out_data  <= ch_data[gnt_idx];
        out_ch    <= gnt_idx;
        if (prio_mode == PRIO_RR) begin
          ptr <= ptr_next;
        end
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fp_rr_mux_stage.sv
// tb/tb_fp_rr_mux_stage.sv - directed table-driven bench for fp_rr_mux_stage
module tb_fp_rr_mux_stage;

  localparam int WIDTH = 24;
  localparam int NCH   = 4;

  typedef struct {
    logic        rst_n;
    logic        prio;
    logic [3:0]  vld;
    logic        ordy;
    logic [95:0] data;
    logic [3:0]  exp_rdy;
    logic        exp_ov;
    logic [23:0] exp_od;
    logic [1:0]  exp_oc;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        prio_mode;
  logic [3:0]  in_valid;
  logic [95:0] in_data;
  logic [3:0]  in_ready;
  logic        out_valid;
  logic [23:0] out_data;
  logic [1:0]  out_ch;
  logic        out_ready;

  int tests = 0;
  int fails = 0;
  vec_t vecs[$];

  fp_rr_mux_stage #(.WIDTH(WIDTH), .NCH(NCH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .prio_mode (prio_mode),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ch    (out_ch),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic r, input logic p, input logic [3:0] v, input logic o,
                              input logic [95:0] d, input logic [3:0] er, input logic eov,
                              input logic [23:0] eod, input logic [1:0] eoc);
    vec_t t;
    t.rst_n = r; t.prio = p; t.vld = v; t.ordy = o; t.data = d;
    t.exp_rdy = er; t.exp_ov = eov; t.exp_od = eod; t.exp_oc = eoc;
    return t;
  endfunction

  initial begin
    logic [95:0] dd;
    logic [95:0] da;
    logic [95:0] db;
    dd = {24'd3, 24'd2, 24'd1, 24'd0};
    da = {24'd3, 24'hABCDEF, 24'd1, 24'd0};
    db = {24'd3, 24'd2, 24'h123456, 24'd0};

    // reset with all channels requesting
    for (int i = 0; i < 3; i++) vecs.push_back(mk(0, 0, 4'b1111, 1, dd, 4'b0000, 0, 24'd0, 2'd0));
    // round-robin fairness
    vecs.push_back(mk(1, 0, 4'b1111, 1, dd, 4'b0001, 1, 24'd0, 2'd0));
    vecs.push_back(mk(1, 0, 4'b1111, 1, dd, 4'b0010, 1, 24'd1, 2'd1));
    vecs.push_back(mk(1, 0, 4'b1111, 1, dd, 4'b0100, 1, 24'd2, 2'd2));
    vecs.push_back(mk(1, 0, 4'b1111, 1, dd, 4'b1000, 1, 24'd3, 2'd3));
    vecs.push_back(mk(1, 0, 4'b1111, 1, dd, 4'b0001, 1, 24'd0, 2'd0));
    vecs.push_back(mk(1, 0, 4'b1111, 1, dd, 4'b0010, 1, 24'd1, 2'd1));
    // fixed priority, ptr=2 stays
    vecs.push_back(mk(1, 1, 4'b1010, 1, dd, 4'b0010, 1, 24'd1, 2'd1));
    vecs.push_back(mk(1, 1, 4'b1010, 1, dd, 4'b0010, 1, 24'd1, 2'd1));
    vecs.push_back(mk(1, 1, 4'b1000, 1, dd, 4'b1000, 1, 24'd3, 2'd3));
    // backpressure: load ABCDEF from ch2 (ptr=2 -> 3), then stall 5 cycles
    vecs.push_back(mk(1, 0, 4'b0100, 1, da, 4'b0100, 1, 24'hABCDEF, 2'd2));
    for (int i = 0; i < 5; i++) vecs.push_back(mk(1, 0, 4'b1111, 0, da, 4'b0000, 1, 24'hABCDEF, 2'd2));
    vecs.push_back(mk(1, 0, 4'b1111, 1, da, 4'b1000, 1, 24'd3, 2'd3));
    // wrap and mode switch: get ptr to 3 via ch2
    vecs.push_back(mk(1, 0, 4'b0100, 1, dd, 4'b0100, 1, 24'd2, 2'd2));
    vecs.push_back(mk(1, 0, 4'b1001, 1, dd, 4'b1000, 1, 24'd3, 2'd3));
    vecs.push_back(mk(1, 0, 4'b1001, 1, dd, 4'b0001, 1, 24'd0, 2'd0));
    vecs.push_back(mk(1, 1, 4'b1001, 1, dd, 4'b0001, 1, 24'd0, 2'd0));
    vecs.push_back(mk(1, 1, 4'b1001, 1, dd, 4'b0001, 1, 24'd0, 2'd0));
    vecs.push_back(mk(1, 0, 4'b1001, 1, dd, 4'b1000, 1, 24'd3, 2'd3));
    // reset mid-transfer (ptr=0 -> ch1 carries 123456)
    vecs.push_back(mk(1, 0, 4'b0010, 1, db, 4'b0010, 1, 24'h123456, 2'd1));
    vecs.push_back(mk(0, 0, 4'b1111, 1, db, 4'b0000, 0, 24'd0, 2'd0));
    vecs.push_back(mk(1, 0, 4'b0000, 1, dd, 4'b0000, 0, 24'd0, 2'd0));
    // empty load holds data, then load while empty despite out_ready=0
    vecs.push_back(mk(1, 0, 4'b0100, 1, dd, 4'b0100, 1, 24'd2, 2'd2));
    vecs.push_back(mk(1, 0, 4'b0000, 1, dd, 4'b0000, 0, 24'd2, 2'd2));
    vecs.push_back(mk(1, 0, 4'b1111, 0, dd, 4'b1000, 1, 24'd3, 2'd3));
    // single requester in RR wins regardless of ptr
    vecs.push_back(mk(1, 0, 4'b0100, 1, dd, 4'b0100, 1, 24'd2, 2'd2));
    vecs.push_back(mk(1, 0, 4'b0100, 1, dd, 4'b0100, 1, 24'd2, 2'd2));

    rst_n = 1'b0; prio_mode = 1'b0; in_valid = '0; in_data = '0; out_ready = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      rst_n = vecs[i].rst_n; prio_mode = vecs[i].prio; in_valid = vecs[i].vld;
      out_ready = vecs[i].ordy; in_data = vecs[i].data;
      #1;
      check("in_ready", i, 32'(in_ready), 32'(vecs[i].exp_rdy));
      @(posedge clk);
      #1;
      check("out_valid", i, 32'(out_valid), 32'(vecs[i].exp_ov));
      check("out_data", i, 32'(out_data), 32'(vecs[i].exp_od));
      check("out_ch", i, 32'(out_ch), 32'(vecs[i].exp_oc));
    end

    // out_ready reaches in_ready combinationally (state: full, ptr=3)
    @(negedge clk);
    in_valid = 4'b1111; in_data = dd; out_ready = 1'b0; prio_mode = 1'b0;
    #1;
    check("hold_ready_low", 100, 32'(in_ready), 32'h0);
    out_ready = 1'b1;
    #1;
    check("ready_follows_out_ready", 101, 32'(in_ready), 32'h8);
    prio_mode = 1'b1;
    #1;
    check("mode_switch_comb", 102, 32'(in_ready), 32'h1);
    prio_mode = 1'b0;
    @(posedge clk);
    #1;
    check("drain_fill_ch", 103, 32'(out_ch), 32'd3);
    check("drain_fill_valid", 104, 32'(out_valid), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
